// File: rtl/alu_dotp_pipe.sv
// Packed int4x8 / int8x4 / int16x2 dot-product ALU with optional accumulate and saturation,
// behind an elastic LATENCY-deep valid/ready pipeline that carries an opaque tag.
module alu_dotp_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 3,
  parameter int TAG_WIDTH = 16,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [1:0]                mode_in,
  input  logic                      signed_in,
  input  logic                      accum_in,
  input  logic [NUM_LANES*XLEN-1:0] rs1_in,
  input  logic [NUM_LANES*XLEN-1:0] rs2_in,
  input  logic [NUM_LANES*XLEN-1:0] rs3_in,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] data_out,
  output logic [TAG_WIDTH-1:0]      tag_out
);

  // Exact dot product of one 32-bit lane; mode 11 falls into the int8 default.
  function automatic logic signed [33:0] dot_lane(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [1:0] mode, input logic sgn);
    logic signed [33:0] acc;
    logic signed [4:0]  a4, b4;
    logic signed [9:0]  p4;
    logic signed [8:0]  a8, b8;
    logic signed [17:0] p8;
    logic signed [16:0] a16, b16;
    logic signed [33:0] p16;
    acc = 34'sd0;
    case (mode)
      2'b01: begin
        for (int i = 0; i < 8; i++) begin
          a4  = {sgn & a[4*i+3], a[4*i +: 4]};
          b4  = {sgn & b[4*i+3], b[4*i +: 4]};
          p4  = 10'(a4) * 10'(b4);
          acc = acc + {{24{p4[9]}}, p4};
        end
      end
      2'b10: begin
        for (int i = 0; i < 2; i++) begin
          a16 = {sgn & a[16*i+15], a[16*i +: 16]};
          b16 = {sgn & b[16*i+15], b[16*i +: 16]};
          p16 = 34'(a16) * 34'(b16);
          acc = acc + p16;
        end
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          a8  = {sgn & a[8*i+7], a[8*i +: 8]};
          b8  = {sgn & b[8*i+7], b[8*i +: 8]};
          p8  = 18'(a8) * 18'(b8);
          acc = acc + {{16{p8[17]}}, p8};
        end
      end
    endcase
    return acc;
  endfunction

  // Optional signed accumulate into a 35-bit exact sum, then wrap or clamp to 32 bits.
  function automatic logic signed [31:0] finish_lane(input logic signed [33:0] dot,
                                                     input logic [31:0] rs3, input logic acc_en);
    logic [34:0] addend;
    logic [34:0] sum;
    addend = acc_en ? {{3{rs3[31]}}, rs3} : 35'd0;
    sum    = {dot[33], dot} + addend;
    if ((SATURATE == 1'b1) && (sum[34:31] != 4'b0000) && (sum[34:31] != 4'b1111)) begin
      return sum[34] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

  logic                      advance_s;
  logic signed [33:0]        in_dot_s   [NUM_LANES];
  logic [31:0]               in_rs3_s   [NUM_LANES];
  logic                      head_valid_s;
  logic                      head_accum_s;
  logic [TAG_WIDTH-1:0]      head_tag_s;
  logic signed [33:0]        head_dot_s [NUM_LANES];
  logic [31:0]               head_rs3_s [NUM_LANES];
  logic [NUM_LANES*XLEN-1:0] result_s;

  // All stages shift together; the only stall source is a held output.
  assign advance_s = !valid_out || ready_out;
  assign ready_in  = advance_s;

  // Products and reduction for the request presented at the input.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      in_dot_s[l] = dot_lane(rs1_in[l*XLEN +: 32], rs2_in[l*XLEN +: 32], mode_in, signed_in);
      in_rs3_s[l] = rs3_in[l*XLEN +: 32];
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      // Output register is the only stage, so it consumes the request directly.
      always_comb begin
        head_valid_s = valid_in;
        head_accum_s = accum_in;
        head_tag_s   = tag_in;
        for (int l = 0; l < NUM_LANES; l++) begin
          head_dot_s[l] = in_dot_s[l];
          head_rs3_s[l] = in_rs3_s[l];
        end
      end
    end else begin : g_stages
      localparam int NM = LATENCY - 1;
      logic                 mid_valid_r [NM];
      logic                 mid_accum_r [NM];
      logic [TAG_WIDTH-1:0] mid_tag_r   [NM];
      logic signed [33:0]   mid_dot_r   [NM][NUM_LANES];
      logic [31:0]          mid_rs3_r   [NM][NUM_LANES];

      // Reduced dot sums travel through the middle stages; payload moves only with a valid.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < NM; s++) begin
            mid_valid_r[s] <= 1'b0;
            mid_accum_r[s] <= 1'b0;
            mid_tag_r[s]   <= {TAG_WIDTH{1'b0}};
            for (int l = 0; l < NUM_LANES; l++) begin
              mid_dot_r[s][l] <= 34'sd0;
              mid_rs3_r[s][l] <= 32'd0;
            end
          end
        end else if (advance_s) begin
          mid_valid_r[0] <= valid_in;
          if (valid_in) begin
            mid_accum_r[0] <= accum_in;
            mid_tag_r[0]   <= tag_in;
            for (int l = 0; l < NUM_LANES; l++) begin
              mid_dot_r[0][l] <= in_dot_s[l];
              mid_rs3_r[0][l] <= in_rs3_s[l];
            end
          end
          for (int s = 1; s < NM; s++) begin
            mid_valid_r[s] <= mid_valid_r[s-1];
            if (mid_valid_r[s-1]) begin
              mid_accum_r[s] <= mid_accum_r[s-1];
              mid_tag_r[s]   <= mid_tag_r[s-1];
              for (int l = 0; l < NUM_LANES; l++) begin
                mid_dot_r[s][l] <= mid_dot_r[s-1][l];
                mid_rs3_r[s][l] <= mid_rs3_r[s-1][l];
              end
            end
          end
        end
      end

      // Last middle stage feeds the output register.
      always_comb begin
        head_valid_s = mid_valid_r[NM-1];
        head_accum_s = mid_accum_r[NM-1];
        head_tag_s   = mid_tag_r[NM-1];
        for (int l = 0; l < NUM_LANES; l++) begin
          head_dot_s[l] = mid_dot_r[NM-1][l];
          head_rs3_s[l] = mid_rs3_r[NM-1][l];
        end
      end
    end
  endgenerate

  // Accumulate/saturate in front of the output register, sign-extended to XLEN.
  always_comb begin
    result_s = {(NUM_LANES*XLEN){1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      result_s[l*XLEN +: XLEN] = XLEN'(finish_lane(head_dot_s[l], head_rs3_s[l], head_accum_s));
    end
  end

  // Output stage: holds data and tag steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      data_out  <= {(NUM_LANES*XLEN){1'b0}};
      tag_out   <= {TAG_WIDTH{1'b0}};
    end else if (advance_s) begin
      valid_out <= head_valid_s;
      if (head_valid_s) begin
        data_out <= result_s;
        tag_out  <= head_tag_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_dotp_pipe.sv
// Scoreboard bench for alu_dotp_pipe: directed arithmetic vectors, a stalled random stream,
// a full-throughput stream and an asynchronous reset with requests in flight.
module tb_alu_dotp_pipe;
  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int LAT = 3;
  localparam int TW  = 16;
  localparam int DW  = NL*XL;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_in, ready_in, signed_in, accum_in;
  logic [1:0]    mode_in;
  logic [DW-1:0] rs1_in, rs2_in, rs3_in;
  logic [TW-1:0] tag_in;
  logic          valid_out, ready_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          s_ready_in, s_valid_out;
  logic [DW-1:0] s_data_out;
  logic [TW-1:0] s_tag_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  logic [1:0]    r_mode;
  logic          r_sgn, r_acc;
  logic [DW-1:0] r_a, r_b, r_c;

  alu_dotp_pipe #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(LAT), .TAG_WIDTH(TW), .SATURATE(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
    .mode_in(mode_in), .signed_in(signed_in), .accum_in(accum_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rs3_in(rs3_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .tag_out(tag_out)
  );

  alu_dotp_pipe #(.NUM_LANES(NL), .XLEN(XL), .LATENCY(1), .TAG_WIDTH(TW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(s_ready_in),
    .mode_in(mode_in), .signed_in(signed_in), .accum_in(accum_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rs3_in(rs3_in), .tag_in(tag_in),
    .valid_out(s_valid_out), .ready_out(1'b1), .data_out(s_data_out), .tag_out(s_tag_out)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic on extracted elements.
  function automatic logic [31:0] model_lane(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [1:0] mode,
                                             input logic sgn, input logic acc, input bit sat);
    int w, n;
    longint s, ea, eb, ua, ub;
    case (mode)
      2'b01:   begin w = 4;  n = 8; end
      2'b10:   begin w = 16; n = 2; end
      default: begin w = 8;  n = 4; end
    endcase
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    s  = 64'sd0;
    for (int i = 0; i < n; i++) begin
      ea = (ua >> (w*i)) & ((64'sd1 << w) - 64'sd1);
      eb = (ub >> (w*i)) & ((64'sd1 << w) - 64'sd1);
      if (sgn && ea >= (64'sd1 << (w-1))) ea = ea - (64'sd1 << w);
      if (sgn && eb >= (64'sd1 << (w-1))) eb = eb - (64'sd1 << w);
      s = s + ea * eb;
    end
    if (acc) s = s + longint'(signed'(c));
    if (sat) begin
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
    end
    return s[31:0];
  endfunction

  function automatic logic [DW-1:0] model_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c, input logic [1:0] mode,
                                              input logic sgn, input logic acc, input bit sat);
    logic [DW-1:0] v;
    v = {DW{1'b0}};
    for (int l = 0; l < NL; l++)
      v[l*XL +: XL] = model_lane(a[l*XL +: 32], b[l*XL +: 32], c[l*XL +: 32], mode, sgn, acc, sat);
    return v;
  endfunction

  task automatic new_req();
    r_mode = 2'($urandom_range(0, 3));
    r_sgn  = 1'($urandom_range(0, 1));
    r_acc  = 1'($urandom_range(0, 1));
    r_a    = {$urandom(), $urandom(), $urandom(), $urandom()};
    r_b    = {$urandom(), $urandom(), $urandom(), $urandom()};
    r_c    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drive_req(input logic [TW-1:0] t);
    valid_in  = 1'b1;
    mode_in   = r_mode;
    signed_in = r_sgn;
    accum_in  = r_acc;
    rs1_in    = r_a;
    rs2_in    = r_b;
    rs3_in    = r_c;
    tag_in    = t;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    mode_in = 2'b00; signed_in = 1'b0; accum_in = 1'b0;
    rs1_in = {DW{1'b0}}; rs2_in = {DW{1'b0}}; rs3_in = {DW{1'b0}}; tag_in = {TW{1'b0}};
    #12;
    checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else passed++;
    checks++; if (data_out !== {DW{1'b0}}) $display("FAIL reset_data: got %h want 0", data_out); else passed++;
    checks++; if (tag_out !== {TW{1'b0}}) $display("FAIL reset_tag: got %h want 0", tag_out); else passed++;
    checks++; if (s_valid_out !== 1'b0) $display("FAIL reset_sat_valid: got %b want 0", s_valid_out); else passed++;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready_in !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_in); else passed++;
  endtask

  // Single request: lane 0 carries the given vector, other lanes are random.
  task automatic test_directed(input string name, input logic [1:0] mode, input logic sgn,
                               input logic acc, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] c0, input logic [31:0] exp0,
                               input logic [31:0] sat0);
    exp_t          e;
    logic [DW-1:0] sexp;
    logic [TW-1:0] t;
    int            lat;
    r_mode = mode; r_sgn = sgn; r_acc = acc;
    r_a = {$urandom(), $urandom(), $urandom(), a0};
    r_b = {$urandom(), $urandom(), $urandom(), b0};
    r_c = {$urandom(), $urandom(), $urandom(), c0};
    e.data = model_vec(r_a, r_b, r_c, mode, sgn, acc, 1'b0);
    e.data[31:0] = exp0;
    sexp = model_vec(r_a, r_b, r_c, mode, sgn, acc, 1'b1);
    sexp[31:0] = sat0;
    t = 16'($urandom());
    e.tag = t;
    @(posedge clk); #1;
    ready_out = 1'b1;
    drive_req(t);
    checks++; if (ready_in !== 1'b1) $display("FAIL %s ready_in: got %b want 1", name, ready_in); else passed++;
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    checks++;
    if (s_valid_out !== 1'b1 || s_data_out !== sexp || s_tag_out !== t)
      $display("FAIL %s sat: got v=%b %h/%h want v=1 %h/%h", name, s_valid_out, s_data_out, s_tag_out, sexp, t);
    else passed++;
    while (valid_out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != LAT) $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); else passed++;
    if (valid_out === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (data_out !== e.data) $display("FAIL %s data: got %h want %h", name, data_out, e.data); else passed++;
      checks++; if (tag_out !== e.tag) $display("FAIL %s tag: got %h want %h", name, tag_out, e.tag); else passed++;
    end else begin
      checks++; $display("FAIL %s output: got no result want one", name);
    end
  endtask

  task automatic test_stream(input int n, input bit rand_ready, input logic [TW-1:0] base);
    int            sent, recv, cyc, first, last, extra;
    bit            held;
    logic [DW-1:0] hd;
    logic [TW-1:0] ht;
    exp_t          e;
    sent = 0; recv = 0; cyc = 0; first = -1; last = -1; held = 1'b0;
    hd = {DW{1'b0}}; ht = {TW{1'b0}};
    new_req();
    @(posedge clk); #1;
    while (recv < n && cyc < 400) begin
      if (sent < n) drive_req(base + TW'(sent)); else valid_in = 1'b0;
      ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== hd || tag_out !== ht)
          $display("FAIL stall_hold: got v=%b %h/%h want v=1 %h/%h", valid_out, data_out, tag_out, hd, ht);
        else passed++;
      end
      checks++;
      if (ready_in !== (!valid_out || ready_out))
        $display("FAIL ready_in: got %b want %b", ready_in, (!valid_out || ready_out));
      else passed++;
      if (valid_out === 1'b1 && ready_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; $display("FAIL stream_extra: got tag %h want none", tag_out);
        end else begin
          e = exp_q.pop_front();
          checks++; if (data_out !== e.data) $display("FAIL stream_data: got %h want %h", data_out, e.data); else passed++;
          checks++; if (tag_out !== e.tag) $display("FAIL stream_tag: got %h want %h", tag_out, e.tag); else passed++;
        end
        recv++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      held = (valid_out === 1'b1) && (ready_out === 1'b0);
      hd = data_out; ht = tag_out;
      if (valid_in === 1'b1 && ready_in === 1'b1) begin
        e.data = model_vec(r_a, r_b, r_c, r_mode, r_sgn, r_acc, 1'b0);
        e.tag  = base + TW'(sent);
        exp_q.push_back(e);
        sent++;
        new_req();
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    checks++; if (recv != n) $display("FAIL stream_count: got %0d want %0d", recv, n); else passed++;
    if (!rand_ready) begin
      checks++;
      if (last - first != n - 1) $display("FAIL throughput: got span %0d want %0d", last - first, n - 1);
      else passed++;
    end
    extra = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) extra++;
    end
    checks++; if (extra != 0 || exp_q.size() != 0) $display("FAIL stream_dup: got %0d extra, %0d pending want 0", extra, exp_q.size()); else passed++;
  endtask

  task automatic test_async_reset();
    int stale;
    @(posedge clk); #1;
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_req();
      drive_req(16'hA000 + TW'(i));
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b1) $display("FAIL rst_inflight: got %b want 1", valid_out); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) $display("FAIL rst_drop: got %b want 0", valid_out); else passed++;
    checks++; if (data_out !== {DW{1'b0}}) $display("FAIL rst_data: got %h want 0", data_out); else passed++;
    checks++; if (tag_out !== {TW{1'b0}}) $display("FAIL rst_tag: got %h want 0", tag_out); else passed++;
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 2*LAT + 2; i++) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) stale++;
    end
    checks++; if (stale != 0) $display("FAIL rst_stale: got %0d valid cycles want 0", stale); else passed++;
    checks++; if (ready_in !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_in); else passed++;
    test_directed("T6_after_reset", 2'b00, 1'b1, 1'b0, 32'h01FF02FE, 32'h04030201, 32'h0, 32'h00000003, 32'h00000003);
  endtask

  initial begin
    test_reset();
    test_directed("T1_i8s",   2'b00, 1'b1, 1'b0, 32'h01FF02FE, 32'h04030201, 32'h0, 32'h00000003, 32'h00000003);
    test_directed("T2_i8u",   2'b00, 1'b0, 1'b0, 32'h01FF02FE, 32'h04030201, 32'h0, 32'h00000403, 32'h00000403);
    test_directed("T3_i4s",   2'b01, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h11111111, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFF8);
    test_directed("T3_i4u",   2'b01, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h11111111, 32'h0, 32'h00000078, 32'h00000078);
    test_directed("T4_i16s",  2'b10, 1'b1, 1'b1, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h00020000, 32'h80000002, 32'h7FFFFFFF);
    test_directed("i16u_max", 2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFC0002, 32'h7FFFFFFF);
    test_directed("mode11",   2'b11, 1'b1, 1'b0, 32'h01FF02FE, 32'h04030201, 32'h0, 32'h00000003, 32'h00000003);
    test_stream(16, 1'b1, 16'h0100);
    test_stream(8, 1'b0, 16'h0200);
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
